// File: rtl/motoro_ramp_ctrl.sv
// Soft-start/soft-stop frequency ramp generator feeding the three-phase commutation core.
// Direction reversals decelerate to zero and coast for a dwell period before restarting.
module motoro_ramp_ctrl #(
  parameter int FREQ_W      = 10,
  parameter int STEP_DIV    = 50000,
  parameter int STEP        = 1,
  parameter int FREQ_MIN    = 10,
  parameter int DWELL_TICKS = 200
) (
  input  logic              clk50mhz,
  input  logic              reset,
  input  logic              m3reqRun,
  input  logic              m3reqDir,
  input  logic [FREQ_W-1:0] m3reqFreq,
  output logic [FREQ_W-1:0] m3freq,
  output logic              m3dir,
  output logic              m3run,
  output logic              m3atSpeed,
  output logic              m3busy
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam int DW_W  = $clog2(DWELL_TICKS + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [DW_W-1:0]   DW_LAST  = DW_W'(DWELL_TICKS - 1);
  localparam logic [FREQ_W-1:0] F_MIN    = FREQ_W'(FREQ_MIN);
  localparam logic [FREQ_W-1:0] F_STEP   = FREQ_W'(STEP);
  // Lowest frequency from which one more decel step still stays at or above FREQ_MIN.
  localparam logic [FREQ_W:0]   STOP_THR = (FREQ_W + 1)'(FREQ_MIN + STEP);

  typedef enum logic [1:0] {IDLE, RAMP, DWELL} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DW_W-1:0]   dwell_reg, dwell_next;
  logic [FREQ_W-1:0] freq_reg, freq_next;
  logic              dir_reg, dir_next;
  logic              run_reg, run_next;
  logic              at_reg, at_next;
  logic              busy_reg, busy_next;

  logic              tick;
  logic [FREQ_W-1:0] tgt;
  logic [FREQ_W:0]   up_sum;
  logic [FREQ_W-1:0] dn_diff;

  assign tick    = (cnt_reg == CNT_LAST);
  // Any stop, reversal or sub-minimum request turns into a ramp towards zero.
  assign tgt     = (!m3reqRun || (m3reqDir != dir_reg) || (m3reqFreq < F_MIN)) ? '0 : m3reqFreq;
  assign up_sum  = {1'b0, freq_reg} + {1'b0, F_STEP};
  assign dn_diff = freq_reg - F_STEP;

  always_ff @(posedge clk50mhz or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dwell_reg <= '0;
      freq_reg  <= '0;
      dir_reg   <= 1'b0;
      run_reg   <= 1'b0;
      at_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dwell_reg <= dwell_next;
      freq_reg  <= freq_next;
      dir_reg   <= dir_next;
      run_reg   <= run_next;
      at_reg    <= at_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = tick ? '0 : cnt_reg + CNT_W'(1);
    dwell_next = dwell_reg;
    freq_next  = freq_reg;
    dir_next   = dir_reg;
    run_next   = run_reg;
    at_next    = (state_reg == RAMP) && (tgt != '0) && (freq_reg == tgt);

    case (state_reg)
      IDLE: begin
        freq_next = '0;
        run_next  = 1'b0;
        if (m3reqRun && (m3reqFreq >= F_MIN)) begin
          state_next = RAMP;
          cnt_next   = '0;
          freq_next  = F_MIN;
          run_next   = 1'b1;
          dir_next   = m3reqDir;
        end
      end
      RAMP: begin
        if (tick) begin
          if (tgt == '0) begin
            if ({1'b0, freq_reg} >= STOP_THR) begin
              freq_next = dn_diff;
            end else begin
              state_next = DWELL;
              cnt_next   = '0;
              dwell_next = '0;
              freq_next  = '0;
              run_next   = 1'b0;
            end
          end else if (freq_reg < tgt) begin
            freq_next = (up_sum > {1'b0, tgt}) ? tgt : up_sum[FREQ_W-1:0];
          end else if (freq_reg > tgt) begin
            // tgt >= FREQ_MIN >= STEP here, so dn_diff cannot underflow.
            freq_next = (dn_diff < tgt) ? tgt : dn_diff;
          end
        end
      end
      DWELL: begin
        freq_next = '0;
        run_next  = 1'b0;
        if (tick) begin
          if (dwell_reg == DW_LAST) begin
            state_next = IDLE;
          end else begin
            dwell_next = dwell_reg + DW_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        freq_next  = '0;
        run_next   = 1'b0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign m3freq    = freq_reg;
  assign m3dir     = dir_reg;
  assign m3run     = run_reg;
  assign m3atSpeed = at_reg;
  assign m3busy    = busy_reg;

endmodule
